// File: rtl/lut_seq_ctrl.sv
// lut_seq_ctrl: steps a LUT-driven datapath through N_ITER iterations.
// Each iteration takes a digit pair from the selector, forwards it to the
// lut_decoder, waits LUT_LAT cycles for the decoder result and then pulses
// dp_upd so the datapath consumes it. The operation can be aborted, frozen
// with enable, or abandoned with the synchronous reset.
module lut_seq_ctrl #(
  parameter int LOG2N   = 6,
  parameter int N_ITER  = 56,
  parameter int LUT_LAT = 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             enable,
  input  logic             start,
  input  logic             abort,
  input  logic             cfg_mode,
  input  logic [1:0]       cfg_format,
  input  logic             dp_d_valid,
  input  logic [1:0]       dp_d_x_n,
  input  logic [1:0]       dp_d_y_n,
  output logic             dp_d_ready,
  output logic             lut_mode,
  output logic [1:0]       lut_format,
  output logic [LOG2N-1:0] lut_n,
  output logic [1:0]       lut_d_x_n,
  output logic [1:0]       lut_d_y_n,
  output logic             dp_upd,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // The wait counter is loaded with LUT_LAT (at most 7) and counts down to 0.
  localparam logic [2:0]       LAT_INIT = 3'(LUT_LAT);
  localparam logic [LOG2N-1:0] LAST_N   = LOG2N'(N_ITER - 1);

  logic [2:0]       r_state;
  logic [2:0]       r_waitCnt;
  logic             r_mode;
  logic [1:0]       r_format;
  logic [LOG2N-1:0] r_lutN;
  logic [1:0]       r_dx;
  logic [1:0]       r_dy;

  logic w_inIssue;
  logic w_inWait;
  logic w_inUpdate;
  logic w_inDone;

  assign w_inIssue  = (r_state == S_ISSUE);
  assign w_inWait   = (r_state == S_WAIT);
  assign w_inUpdate = (r_state == S_UPDATE);
  assign w_inDone   = (r_state == S_DONE);

  // Handshake and pulses are qualified by enable so a frozen cycle never
  // repeats a pulse; an abort in UPDATE suppresses the update it cancels.
  assign dp_d_ready = enable && w_inIssue;
  assign dp_upd     = enable && w_inUpdate && !abort;
  assign done       = enable && w_inDone;
  assign busy       = w_inIssue || w_inWait || w_inUpdate;

  assign lut_mode   = r_mode;
  assign lut_format = r_format;
  assign lut_n      = r_lutN;
  assign lut_d_x_n  = r_dx;
  assign lut_d_y_n  = r_dy;

  // Sequencer state, wait counter and the registered lut_decoder inputs;
  // reset wins over everything, then enable freezes all state.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state   <= S_IDLE;
      r_waitCnt <= 3'd0;
      r_mode    <= 1'b0;
      r_format  <= 2'b00;
      r_lutN    <= '0;
      r_dx      <= 2'b00;
      r_dy      <= 2'b00;
    end else if (enable) begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_mode   <= cfg_mode;
            r_format <= cfg_format;
            r_lutN   <= '0;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (dp_d_valid) begin
            r_dx      <= dp_d_x_n;
            r_dy      <= dp_d_y_n;
            r_waitCnt <= LAT_INIT;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            r_waitCnt <= 3'd0;
            r_state   <= S_IDLE;
          end else begin
            r_waitCnt <= r_waitCnt - 3'd1;
            if (r_waitCnt == 3'd1) begin
              r_state <= S_UPDATE;
            end
          end
        end
        S_UPDATE: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (r_lutN == LAST_N) begin
            r_state <= S_DONE;
          end else begin
            r_lutN  <= r_lutN + LOG2N'(1);
            r_state <= S_ISSUE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
